// File: rtl/car_select_pkg.sv
// Shared types and elaboration-time helpers for the car-selection sequencer.
package car_select_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_INTRO  = 3'd1,
      ST_DECIDE = 3'd2,
      ST_PATH   = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   // Codes 5-7 are unreachable; if one appears the FSM falls back here.
   localparam state_t ST_RECOVER = ST_IDLE;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int path_len(input int c, input int base, input int step);
      return base + c * step;
   endfunction

endpackage

// File: rtl/car_select_timeout.sv
// Decision-window timer: reloads while disabled, counts down while enabled,
// and flags expiry on the cycle it sits at zero.
module car_select_timeout #(
   parameter int          W    = 1,
   parameter int unsigned LOAD = 0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   output logic o_expired
);
   localparam logic [W-1:0] LOAD_V = W'(LOAD);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= LOAD_V;
      end else if (!i_en) begin
         r_cnt <= LOAD_V;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_expired = i_en && (r_cnt == '0);

endmodule

// File: rtl/car_select_sequencer.sv
// Car-selection sequencer: intro steps, a decision handshake with optional
// timeout fallback, a choice-dependent path, then a terminal DONE state.
module car_select_sequencer
   import car_select_pkg::*;
#(
   parameter  int INTRO_LEN      = 7,
   parameter  int NUM_CHOICES    = 2,
   parameter  int BASE_LEN       = 2,
   parameter  int LEN_STEP       = 1,
   parameter  int TIMEOUT        = 0,
   parameter  int DEFAULT_CHOICE = 0,
   localparam int CHOICE_W       = max2(1, clog2(NUM_CHOICES)),
   localparam int CNT_W          = clog2(max2(INTRO_LEN,
                                     path_len(NUM_CHOICES - 1, BASE_LEN, LEN_STEP)) + 1)
) (
   input  logic                Clock,
   input  logic                Resetn,
   input  logic                Start,
   input  logic                Abort,
   input  logic                Restart,
   input  logic                Advance,
   input  logic [CHOICE_W-1:0] Choice,
   input  logic                Choice_valid,
   output logic                Choice_ready,
   output logic                Result,
   output logic [CHOICE_W-1:0] Selected,
   output logic                Timed_out,
   output logic                Choice_err,
   output logic [2:0]          CurState,
   output logic [CNT_W-1:0]    StepCount
);
   localparam logic [CNT_W-1:0]    INTRO_LAST = CNT_W'(INTRO_LEN - 1);
   localparam logic [CHOICE_W:0]   NUM_C      = (CHOICE_W + 1)'(NUM_CHOICES);
   localparam logic [CHOICE_W-1:0] DEF_C      = CHOICE_W'(DEFAULT_CHOICE);

   state_t              r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_step, w_step_nxt;
   logic [CHOICE_W-1:0] r_selected, w_sel_nxt;
   logic                r_timed_out, w_to_nxt;
   logic                r_choice_err, w_err_nxt;
   logic                w_expired;
   logic                w_choice_ok;
   logic [CNT_W-1:0]    w_path_last;

   generate
      if (TIMEOUT > 0) begin : g_timeout
         car_select_timeout #(
            .W    (max2(1, clog2(TIMEOUT))),
            .LOAD (TIMEOUT - 1)
         ) u_timeout (
            .i_clk     (Clock),
            .i_rst_n   (Resetn),
            .i_en      (r_state == ST_DECIDE),
            .o_expired (w_expired)
         );
      end else begin : g_no_timeout
         assign w_expired = 1'b0;
      end
   endgenerate

   // Choice handshake: Choice_ready is high exactly while in DECIDE; a beat
   // transfers when Choice_valid && Choice_ready and Choice < NUM_CHOICES.
   // An out-of-range beat is refused and reported by Choice_err next cycle.
   assign w_choice_ok = Choice_valid && ({1'b0, Choice} < NUM_C);
   assign w_path_last = CNT_W'(path_len(int'(r_selected), BASE_LEN, LEN_STEP) - 1);

   always_comb begin
      w_state_nxt = r_state;
      w_step_nxt  = r_step;
      w_sel_nxt   = r_selected;
      w_to_nxt    = r_timed_out;
      w_err_nxt   = 1'b0;
      if (Abort) begin
         w_state_nxt = ST_IDLE;
         w_step_nxt  = '0;
      end else begin
         case (r_state)
            ST_IDLE: if (Start) begin
               w_state_nxt = ST_INTRO;
               w_step_nxt  = '0;
               w_sel_nxt   = '0;
               w_to_nxt    = 1'b0;
            end
            ST_INTRO: if (Advance) begin
               if (r_step == INTRO_LAST) begin
                  w_state_nxt = ST_DECIDE;
                  w_step_nxt  = '0;
               end else begin
                  w_step_nxt = r_step + CNT_W'(1);
               end
            end
            ST_DECIDE: begin
               // An accepted choice on the expiry cycle beats the fallback.
               if (w_choice_ok) begin
                  w_sel_nxt   = Choice;
                  w_state_nxt = ST_PATH;
                  w_step_nxt  = '0;
               end else begin
                  w_err_nxt = Choice_valid;
                  if (w_expired) begin
                     w_sel_nxt   = DEF_C;
                     w_to_nxt    = 1'b1;
                     w_state_nxt = ST_PATH;
                     w_step_nxt  = '0;
                  end
               end
            end
            ST_PATH: if (Advance) begin
               w_step_nxt = r_step + CNT_W'(1);
               if (r_step == w_path_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: if (Restart) begin
               w_state_nxt = ST_IDLE;
               w_step_nxt  = '0;
            end
            default: begin
               w_state_nxt = ST_RECOVER;
               w_step_nxt  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_state      <= ST_IDLE;
         r_step       <= '0;
         r_selected   <= '0;
         r_timed_out  <= 1'b0;
         r_choice_err <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_step       <= w_step_nxt;
         r_selected   <= w_sel_nxt;
         r_timed_out  <= w_to_nxt;
         r_choice_err <= w_err_nxt;
      end
   end

   assign Choice_ready = (r_state == ST_DECIDE);
   assign Result       = (r_state == ST_DONE);
   assign Selected     = r_selected;
   assign Timed_out    = r_timed_out;
   assign Choice_err   = r_choice_err;
   assign CurState     = r_state;
   assign StepCount    = r_step;

endmodule

// File: tb/tb_car_select_sequencer.sv
// Randomised and directed bench for car_select_sequencer against a
// cycle-level reference model; a monitor pops expected snapshots each clock.
module tb_car_select_sequencer;
   localparam int INTRO_LEN      = 7;
   localparam int NUM_CHOICES    = 3;
   localparam int BASE_LEN       = 2;
   localparam int LEN_STEP       = 1;
   localparam int TIMEOUT        = 5;
   localparam int DEFAULT_CHOICE = 1;
   localparam int SNAP_W         = 12;

   logic       Clock = 1'b0;
   logic       Resetn = 1'b1;
   logic       Start = 1'b0, Abort = 1'b0, Restart = 1'b0, Advance = 1'b0;
   logic [1:0] Choice = 2'd0;
   logic       Choice_valid = 1'b0;
   logic       Choice_ready, Result, Timed_out, Choice_err;
   logic [1:0] Selected;
   logic [2:0] CurState, StepCount;

   car_select_sequencer #(
      .INTRO_LEN      (INTRO_LEN),
      .NUM_CHOICES    (NUM_CHOICES),
      .BASE_LEN       (BASE_LEN),
      .LEN_STEP       (LEN_STEP),
      .TIMEOUT        (TIMEOUT),
      .DEFAULT_CHOICE (DEFAULT_CHOICE)
   ) dut (
      .Clock        (Clock),
      .Resetn       (Resetn),
      .Start        (Start),
      .Abort        (Abort),
      .Restart      (Restart),
      .Advance      (Advance),
      .Choice       (Choice),
      .Choice_valid (Choice_valid),
      .Choice_ready (Choice_ready),
      .Result       (Result),
      .Selected     (Selected),
      .Timed_out    (Timed_out),
      .Choice_err   (Choice_err),
      .CurState     (CurState),
      .StepCount    (StepCount)
   );

   // ---------------- clock ----------------
   always #5 Clock = ~Clock;

   // ---------------- scoreboard state ----------------
   logic [SNAP_W-1:0] exp_q[$];
   logic [2:0]        done_q[$];
   int checks = 0;
   int errors = 0;
   int cyc_no = 0;

   // Reference model: phase names follow the published state codes.
   int m_phase, m_steps, m_sel, m_to, m_err, m_wait;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_steps = 0; m_sel = 0; m_to = 0; m_err = 0; m_wait = 0;
   endtask

   task automatic model_step(input logic st, input logic ab, input logic rs,
                             input logic adv, input logic cv, input logic [1:0] ch);
      int len;
      m_err = 0;
      if (ab) begin
         m_phase = 0;
         m_steps = 0;
      end else begin
         case (m_phase)
            0: if (st) begin
               m_phase = 1; m_steps = 0; m_sel = 0; m_to = 0;
            end
            1: if (adv) begin
               m_steps++;
               if (m_steps == INTRO_LEN) begin
                  m_phase = 2; m_steps = 0; m_wait = 0;
               end
            end
            2: begin
               if (cv && int'(ch) < NUM_CHOICES) begin
                  m_sel = int'(ch); m_phase = 3; m_steps = 0;
               end else begin
                  if (cv) m_err = 1;
                  if (TIMEOUT > 0 && m_wait == TIMEOUT - 1) begin
                     m_sel = DEFAULT_CHOICE; m_to = 1; m_phase = 3; m_steps = 0;
                  end else begin
                     m_wait++;
                  end
               end
            end
            3: if (adv) begin
               m_steps++;
               len = BASE_LEN + m_sel * LEN_STEP;
               if (m_steps == len) begin
                  m_phase = 4;
                  done_q.push_back({2'(m_sel), 1'(m_to)});
               end
            end
            4: if (rs) begin
               m_phase = 0; m_steps = 0;
            end
            default: m_phase = 0;
         endcase
      end
      exp_q.push_back({3'(m_phase), 3'(m_steps), 2'(m_sel), 1'(m_to), 1'(m_err),
                       (m_phase == 4), (m_phase == 2)});
   endtask

   // ---------------- driver ----------------
   task automatic cyc(input logic st, input logic ab, input logic rs,
                      input logic adv, input logic cv, input logic [1:0] ch);
      @(negedge Clock);
      Start = st; Abort = ab; Restart = rs; Advance = adv;
      Choice_valid = cv; Choice = ch;
      model_step(st, ab, rs, adv, cv, ch);
   endtask

   task automatic to_decide();
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      for (int i = 0; i < INTRO_LEN; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
   endtask

   // ---------------- monitor ----------------
   logic [SNAP_W-1:0] mon_act, mon_exp;
   logic [2:0]        mon_done;
   logic              prev_res = 1'b0;

   initial begin : monitor
      forever begin
         @(posedge Clock);
         #1;
         cyc_no++;
         if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {CurState, StepCount, Selected, Timed_out, Choice_err, Result, Choice_ready};
            checks++;
            if (mon_act !== mon_exp) begin
               errors++;
               $display("FAIL snapshot cyc %0d actual st=%0d cnt=%0d sel=%0d to=%0d err=%0d res=%0d rdy=%0d expected st=%0d cnt=%0d sel=%0d to=%0d err=%0d res=%0d rdy=%0d",
                        cyc_no, mon_act[11:9], mon_act[8:6], mon_act[5:4], mon_act[3], mon_act[2], mon_act[1], mon_act[0],
                        mon_exp[11:9], mon_exp[8:6], mon_exp[5:4], mon_exp[3], mon_exp[2], mon_exp[1], mon_exp[0]);
            end
         end
         if (Result && !prev_res) begin
            checks++;
            if (done_q.size() == 0) begin
               errors++;
               $display("FAIL done_unexpected cyc %0d actual Result=1 expected Result=0", cyc_no);
            end else begin
               mon_done = done_q.pop_front();
               if ({Selected, Timed_out} !== mon_done) begin
                  errors++;
                  $display("FAIL done_result cyc %0d actual sel=%0d to=%0d expected sel=%0d to=%0d",
                           cyc_no, Selected, Timed_out, mon_done[2:1], mon_done[0]);
               end
            end
         end
         prev_res = Result;
      end
   end

   // ---------------- stimulus ----------------
   int lat;
   logic got;

   initial begin : stimulus
      model_reset();
      #1 Resetn = 1'b0;
      #2;
      check("reset_state", int'(CurState), 0);
      check("reset_step", int'(StepCount), 0);
      check("reset_result", int'(Result), 0);
      check("reset_ready", int'(Choice_ready), 0);
      @(negedge Clock);
      @(negedge Clock);
      Resetn = 1'b1;

      // Latency with Advance held and a choice waiting at DECIDE entry.
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1);
      lat = -1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge Clock);
         #1;
         lat++;
         if (Result) got = 1'b1;
         else cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1);
      end
      check("latency_to_done", lat, INTRO_LEN + 1 + (BASE_LEN + 1 * LEN_STEP));
      check("latency_selected", int'(Selected), 1);
      check("latency_timed_out", int'(Timed_out), 0);
      // Start ignored in DONE, Restart leaves.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);

      // Out-of-range choice, then the longest path.
      to_decide();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);

      // Timeout fallback.
      to_decide();
      for (int i = 0; i < TIMEOUT; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      @(posedge Clock);
      #1;
      check("timeout_state", int'(CurState), 3);
      check("timeout_selected", int'(Selected), DEFAULT_CHOICE);
      check("timeout_flag", int'(Timed_out), 1);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);

      // Valid choice on the expiry cycle wins.
      to_decide();
      for (int i = 0; i < TIMEOUT - 1; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
      @(posedge Clock);
      #1;
      check("expiry_choice_state", int'(CurState), 3);
      check("expiry_choice_selected", int'(Selected), 0);
      check("expiry_choice_flag", int'(Timed_out), 0);
      for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);

      // Advance toggling through INTRO, then Abort beats a valid choice.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      for (int i = 0; i < 2 * INTRO_LEN; i++)
         cyc(1'b0, 1'b0, 1'b0, (i % 2 == 0), 1'b0, 2'd0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

      // Asynchronous reset between edges in the middle of PATH.
      to_decide();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
      @(posedge Clock);
      #3;
      Start = 1'b0; Abort = 1'b0; Restart = 1'b0; Advance = 1'b0; Choice_valid = 1'b0;
      Resetn = 1'b0;
      #1;
      check("async_state", int'(CurState), 0);
      check("async_step", int'(StepCount), 0);
      check("async_selected", int'(Selected), 0);
      check("async_timed_out", int'(Timed_out), 0);
      check("async_err", int'(Choice_err), 0);
      check("async_result", int'(Result), 0);
      check("async_ready", int'(Choice_ready), 0);
      model_reset();
      done_q.delete();
      @(negedge Clock);
      @(negedge Clock);
      Resetn = 1'b1;

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0),
             ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)));
      end

      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      repeat (3) @(posedge Clock);
      #2;
      check("exp_q_drained", exp_q.size(), 0);
      check("done_q_drained", done_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
